// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: op/state encodings and op-to-gate-family decode for logic_gate_accum
package logic_gate_pkg;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_PASS_A, OP_NOT_A
  } op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_OUTPUT} state_e;
  typedef enum logic [1:0] {B_AND, B_OR, B_XOR, B_PASS} base_e;
  function automatic base_e base_of(input op_e op);
    return (op == OP_AND || op == OP_NAND) ? B_AND :
           (op == OP_OR  || op == OP_NOR)  ? B_OR  :
           (op == OP_XOR || op == OP_XNOR) ? B_XOR : B_PASS;
  endfunction
  function automatic logic inv_of(input op_e op);
    return op inside {OP_NAND, OP_NOR, OP_XNOR, OP_NOT_A};
  endfunction
endpackage

// File: rtl/logic_gate_accum_gate_combine.sv
// gate_combine: folds one operand pair into the running accumulator for a gate family
module gate_combine
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  base_e            fam,
  input  logic             first,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  // first beat seeds from the operand pair alone; later beats fold acc in
  always_comb begin
    y = fam == B_AND ? (first ? a & b : acc & a & b) :
        fam == B_OR  ? (first ? a | b : acc | a | b) :
        fam == B_XOR ? (first ? a ^ b : acc ^ a ^ b) : a;
  end
endmodule

// File: rtl/logic_gate_accum.sv
// logic_gate_accum: multi-beat bitwise gate reduction over a valid/ready packet stream
// Optional m_parity output when LOGIC_GATE_ACCUM_PARITY_EN is defined.
module logic_gate_accum
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic [2:0]       s_op,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] m_count,
  output logic             m_ovf
`ifdef LOGIC_GATE_ACCUM_PARITY_EN
  ,
  output logic             m_parity
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e state, state_nx;
  op_e op_q, op_cur;
  base_e fam;
  logic [WIDTH-1:0] acc, acc_nx, res;
  logic [CNT_W-1:0] count, count_nx;
  logic ovf, ovf_nx, first, s_fire, m_fire;
  assign first    = state == ST_IDLE;
  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;
  assign op_cur   = first ? op_e'(s_op) : op_q;
  assign fam      = base_of(op_cur);
  assign res      = inv_of(op_cur) ? ~acc_nx : acc_nx;
  assign count_nx = first ? CNT_W'(1) : (count == CNT_MAX ? count : count + 1'b1);
  assign ovf_nx   = !first && (ovf || count == CNT_MAX);
  gate_combine #(.WIDTH(WIDTH)) u_gate (
    .fam   (fam),
    .first (first),
    .acc   (acc),
    .a     (s_a),
    .b     (s_b),
    .y     (acc_nx)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end
  // next state: hold the result until taken, otherwise advance on accepted beats
  always_comb begin
    state_nx = state == ST_OUTPUT ? (m_ready ? ST_IDLE : ST_OUTPUT) :
               s_fire ? (s_last ? ST_OUTPUT : ST_ACCUM) : state;
  end
  // handshake outputs decoded from state; input closed while reset is held
  always_comb begin
    s_ready = !rst && state != ST_OUTPUT;
    m_valid = state == ST_OUTPUT;
  end
  // accumulator, latched op and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      op_q  <= OP_AND;
      count <= '0;
      ovf   <= 1'b0;
    end else if (s_fire) begin
      acc   <= acc_nx;
      op_q  <= op_cur;
      count <= count_nx;
      ovf   <= ovf_nx;
    end else if (m_fire) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end
  end
  // result registers load on the closing beat and hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data   <= '0;
      m_count  <= '0;
      m_ovf    <= 1'b0;
`ifdef LOGIC_GATE_ACCUM_PARITY_EN
      m_parity <= 1'b0;
`endif
    end else if (s_fire && s_last) begin
      m_data   <= res;
      m_count  <= count_nx;
      m_ovf    <= ovf_nx;
`ifdef LOGIC_GATE_ACCUM_PARITY_EN
      m_parity <= ^res;
`endif
    end
  end
endmodule
